// File: rtl/sd_pkg.sv
// Shared constants for the N-piece sigma-delta modulator.
//   SD_BITWIDTH : default accumulator / K width
//   SD_NPIECE   : default number of bitstream samples produced per clock
//   SD_K_INIT   : K word loaded into k_active on reset
package sd_pkg;

    localparam int SD_BITWIDTH = 40;
    localparam int SD_NPIECE   = 4;

    localparam logic [SD_BITWIDTH-1:0] SD_K_INIT = {24'h000e2c, 16'he2c0};

endpackage

// File: rtl/sd_piece_stage.sv
// One slice of the unrolled sigma-delta chain: adds K to the running
// accumulator value and exposes the carry as the bitstream sample.
//   a_in  : accumulator value entering this slice
//   k     : active K word
//   a_out : accumulator value handed to the next slice (wraps mod 2^WIDTH)
//   carry : output sample for this slice
module sd_piece_stage
    import sd_pkg::*;
#(
    parameter int WIDTH = SD_BITWIDTH
) (
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] a_out,
    output logic             carry
);

    assign {carry, a_out} = {1'b0, a_in} + {1'b0, k};

endmodule

// File: rtl/sigma_delta_npiece.sv
// N-piece first-order sigma-delta modulator. Each clock emits NPIECE
// consecutive bitstream samples; density of ones is k_active / 2^BITWIDTH.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-high; clears all state
//   enable   : 1 advances the modulator, 0 holds acc and zeroes sd_out
//   k_in     : new K word, taken when k_valid & k_ready
//   k_valid  : k_in is valid
//   k_ready  : K can be accepted (low while ramping)
//   ramp_en  : add k_step to k_active on every enabled clock
//   k_step   : ramp increment
//   ramp_sat : sticky flag, ramp clipped at full scale
//   sd_out   : bitstream frame, bit 0 is the earliest sample
//   sd_valid : sd_out holds an enabled frame
module sigma_delta_npiece
    import sd_pkg::*;
#(
    parameter int                  NPIECE   = SD_NPIECE,
    parameter int                  BITWIDTH = SD_BITWIDTH,
    parameter logic [BITWIDTH-1:0] ACC_INIT = '0,
    parameter logic [BITWIDTH-1:0] K_INIT   = BITWIDTH'(SD_K_INIT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [BITWIDTH-1:0] k_in,
    input  logic                k_valid,
    output logic                k_ready,
    input  logic                ramp_en,
    input  logic [BITWIDTH-1:0] k_step,
    output logic                ramp_sat,
    output logic [NPIECE-1:0]   sd_out,
    output logic                sd_valid
);

    localparam logic [BITWIDTH-1:0] K_MAX = '1;

    logic [BITWIDTH-1:0] acc_reg;
    logic [BITWIDTH-1:0] k_active_reg;
    logic [BITWIDTH-1:0] k_next;
    logic                ramp_sat_reg;
    logic                ramp_sat_next;
    logic [NPIECE-1:0]   sd_out_reg;
    logic                sd_valid_reg;

    logic [BITWIDTH-1:0] a_chain [NPIECE+1];
    logic [NPIECE-1:0]   carry_vec;
    logic [BITWIDTH:0]   ramp_sum;

    // Unrolled accumulator chain: slice j produces sample j of this frame.
    assign a_chain[0] = acc_reg;

    generate
        for (genvar gi = 0; gi < NPIECE; gi++) begin : g_piece
            sd_piece_stage #(
                .WIDTH (BITWIDTH)
            ) u_stage (
                .a_in  (a_chain[gi]),
                .k     (k_active_reg),
                .a_out (a_chain[gi+1]),
                .carry (carry_vec[gi])
            );
        end
    endgenerate

    // Loading and ramping are mutually exclusive through k_ready.
    assign k_ready = !ramp_en;

    always_comb begin
        ramp_sum      = {1'b0, k_active_reg} + {1'b0, k_step};
        k_next        = k_active_reg;
        ramp_sat_next = ramp_sat_reg;
        if (k_valid && k_ready) begin
            k_next = k_in;
        end else if (ramp_en && enable) begin
            // Carry out of the wide sum means the ramp went past full scale.
            if (ramp_sum[BITWIDTH]) begin
                k_next        = K_MAX;
                ramp_sat_next = 1'b1;
            end else begin
                k_next = ramp_sum[BITWIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg      <= ACC_INIT;
            k_active_reg <= K_INIT;
            ramp_sat_reg <= 1'b0;
            sd_out_reg   <= '0;
            sd_valid_reg <= 1'b0;
        end else begin
            k_active_reg <= k_next;
            ramp_sat_reg <= ramp_sat_next;
            sd_valid_reg <= enable;
            if (enable) begin
                acc_reg    <= a_chain[NPIECE];
                sd_out_reg <= carry_vec;
            end else begin
                sd_out_reg <= '0;
            end
        end
    end

    assign sd_out   = sd_out_reg;
    assign sd_valid = sd_valid_reg;
    assign ramp_sat = ramp_sat_reg;

endmodule

// File: tb/tb_sigma_delta_npiece.sv
module tb_sigma_delta_npiece;

    localparam int          NP    = 4;
    localparam int          BW    = 40;
    localparam logic [63:0] FULL  = 64'd1 << BW;
    localparam logic [63:0] MASK  = FULL - 64'd1;
    localparam logic [63:0] KINIT = {24'd0, 24'h000e2c, 16'he2c0};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [BW-1:0] k_in = '0;
    logic          k_valid = 1'b0;
    logic          k_ready;
    logic          ramp_en = 1'b0;
    logic [BW-1:0] k_step = '0;
    logic          ramp_sat;
    logic [NP-1:0] sd_out;
    logic          sd_valid;

    int checks = 0;
    int passed = 0;

    // expected {ramp_sat, sd_valid, sd_out} for each upcoming edge
    logic [NP+1:0] exp_q [$];

    // reference state
    logic [63:0] m_acc;
    logic [63:0] m_k;
    logic        m_sat;

    sigma_delta_npiece dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .k_in     (k_in),
        .k_valid  (k_valid),
        .k_ready  (k_ready),
        .ramp_en  (ramp_en),
        .k_step   (k_step),
        .ramp_sat (ramp_sat),
        .sd_out   (sd_out),
        .sd_valid (sd_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    // Monitor: compares each registered frame just after the edge.
    initial begin
        logic [NP+1:0] e;
        logic [NP+1:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {ramp_sat, sd_valid, sd_out};
                checks++;
                if (a === e) passed++;
                else $display("FAIL frame t=%0t: got sat/valid/out=%b/%b/%b want %b/%b/%b",
                              $time, a[NP+1], a[NP], a[NP-1:0], e[NP+1], e[NP], e[NP-1:0]);
            end
        end
    end

    // Sample n of a first-order modulator is the increment of
    // floor((acc0 + n*K) / 2^BW); frame bits follow directly from that.
    function automatic logic [NP-1:0] frame_bits(input logic [63:0] acc, input logic [63:0] k);
        logic [NP-1:0] b;
        for (int j = 0; j < NP; j++) begin
            logic [63:0] lo;
            logic [63:0] hi;
            lo = (acc + 64'(j) * k) >> BW;
            hi = (acc + 64'(j + 1) * k) >> BW;
            b[j] = (hi - lo) != 0;
        end
        return b;
    endfunction

    task automatic model_reset();
        m_acc = 64'd0;
        m_k   = KINIT;
        m_sat = 1'b0;
    endtask

    task automatic step(input bit en, input bit kv, input logic [BW-1:0] kin,
                        input bit rp, input logic [BW-1:0] ks);
        logic [NP-1:0] bits;
        logic [63:0]   s;
        @(negedge clk);
        enable  = en;
        k_valid = kv;
        k_in    = kin;
        ramp_en = rp;
        k_step  = ks;
        #1;
        checks++;
        if (k_ready === !rp) passed++;
        else $display("FAIL k_ready: got %b want %b", k_ready, !rp);
        bits = '0;
        if (en) begin
            bits  = frame_bits(m_acc, m_k);
            m_acc = (m_acc + 64'(NP) * m_k) & MASK;
        end
        if (kv && !rp) begin
            m_k = 64'(kin);
        end else if (rp && en) begin
            s = m_k + 64'(ks);
            if (s > MASK) begin
                m_k   = MASK;
                m_sat = 1'b1;
            end else begin
                m_k = s;
            end
        end
        exp_q.push_back({m_sat, en, bits});
    endtask

    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++) step(en, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic load(input logic [BW-1:0] kin);
        step(1'b1, 1'b1, kin, 1'b0, '0);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for clk.
    task automatic mid_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (sd_out === '0 && sd_valid === 1'b0 && ramp_sat === 1'b0) passed++;
        else $display("FAIL async_reset: got out/valid/sat=%b/%b/%b want 0000/0/0",
                      sd_out, sd_valid, ramp_sat);
        model_reset();
        @(negedge clk);
        enable  = 1'b1;
        k_valid = 1'b0;
        ramp_en = 1'b0;
        exp_q.push_back('0);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0]   r;
        logic [BW-1:0] kin;
        logic [BW-1:0] ks;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sd_out === '0 && sd_valid === 1'b0 && ramp_sat === 1'b0) passed++;
        else $display("FAIL reset_state: got out/valid/sat=%b/%b/%b want 0000/0/0",
                      sd_out, sd_valid, ramp_sat);
        @(negedge clk);
        reset = 1'b0;

        // half scale: 1010 pattern
        load(40'h80_0000_0000);
        run(6, 1'b1);
        // quarter scale: 1000 pattern over 64 frames
        load(40'h40_0000_0000);
        run(64, 1'b1);
        // full scale, then zero with one-clock latency
        load(40'hFF_FFFF_FFFF);
        run(4, 1'b1);
        load(40'h0);
        run(4, 1'b1);
        // ramp to clip, with ignored load attempts
        load(40'h40_0000_0000);
        for (int i = 0; i < 6; i++)
            step(1'b1, i[0], 40'h12_3456_789A, 1'b1, 40'h40_0000_0000);
        // ramp with enable low holds K
        step(1'b0, 1'b0, '0, 1'b1, 40'h1);
        run(2, 1'b1);
        // enable gap mid-stream
        mid_reset();
        load(40'h55_5555_5555);
        run(5, 1'b1);
        run(3, 1'b0);
        run(5, 1'b1);
        // async reset mid-run, then K_INIT pattern from ACC_INIT
        mid_reset();
        run(8, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit en;
            bit kv;
            bit rp;
            r   = {$urandom(), $urandom()};
            kin = r[BW-1:0] >> $urandom_range(0, 8);
            if ($urandom_range(0, 15) == 0) kin = '1;
            if ($urandom_range(0, 15) == 0) kin = '0;
            r   = {$urandom(), $urandom()};
            ks  = r[BW-1:0] >> $urandom_range(4, 39);
            en  = $urandom_range(0, 9) != 0;
            kv  = $urandom_range(0, 4) == 0;
            rp  = $urandom_range(0, 7) == 0;
            if (i == 200) mid_reset();
            step(en, kv, kin, rp, ks);
        end
        run(2, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
